// File: rtl/staged_counter_pair.sv
// Two-stage counter pair: x warms up to a latched limit, then y counts (optionally cyclic).
// Latency: all outputs registered one edge after the enabling inputs; at_limit decodes state directly.
// Backpressure: en=0 freezes all state (y_wrap drops); clr overrides en and returns to IDLE.
module staged_counter_pair #(
    parameter int WIDTH   = 4,
    parameter bit STEP_EN = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             clr,
    input  logic             mode,
    input  logic [WIDTH-1:0] limit,
    input  logic [WIDTH-1:0] step,
    output logic [WIDTH-1:0] x,
    output logic [WIDTH-1:0] y,
    output logic [1:0]       state,
    output logic             at_limit,
    output logic             y_wrap
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_WARM = 2'b01,
        ST_RUN  = 2'b10
    } state_t;

    localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);
    localparam logic [WIDTH-1:0] ZERO = '0;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] x_q, x_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic [WIDTH-1:0] limit_q, limit_d;
    logic             y_wrap_q, y_wrap_d;
    logic [WIDTH-1:0] inc;
    logic [WIDTH:0]   y_sum;

    // y increment source, and the carry-extended sum used for wrap detection
    always_comb begin
        inc   = STEP_EN ? step : ONE;
        y_sum = {1'b0, y_q} + {1'b0, inc};
    end

    // Next-state: clr beats freeze, freeze beats the FSM; the unused encoding behaves as IDLE
    always_comb begin
        state_d  = state_q;
        x_d      = x_q;
        y_d      = y_q;
        limit_d  = limit_q;
        y_wrap_d = 1'b0;
        if (clr) begin
            state_d = ST_IDLE;
            x_d     = ZERO;
            y_d     = ZERO;
        end else if (en) begin
            case (state_q)
                ST_WARM: begin
                    y_d = ZERO;
                    if (x_q == limit_q) begin
                        state_d = ST_RUN;
                    end else begin
                        x_d = x_q + ONE;
                    end
                end
                ST_RUN: begin
                    x_d = limit_q;
                    y_d = y_sum[WIDTH-1:0];
                    if (y_sum[WIDTH]) begin
                        y_wrap_d = 1'b1;
                        // cyclic mode restarts warm-up with the limit captured earlier
                        if (mode) begin
                            state_d = ST_WARM;
                            x_d     = ZERO;
                            y_d     = ZERO;
                        end
                    end
                end
                default: begin
                    limit_d = limit;
                    x_d     = ZERO;
                    y_d     = ZERO;
                    state_d = ST_WARM;
                end
            endcase
        end
    end

    // State registers with asynchronous active-high reset
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            x_q      <= ZERO;
            y_q      <= ZERO;
            limit_q  <= ZERO;
            y_wrap_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            x_q      <= x_d;
            y_q      <= y_d;
            limit_q  <= limit_d;
            y_wrap_q <= y_wrap_d;
        end
    end

    // Output mapping; at_limit is a direct decode of the registered state
    always_comb begin
        x        = x_q;
        y        = y_q;
        state    = state_q;
        at_limit = (state_q == ST_RUN);
        y_wrap   = y_wrap_q;
    end

endmodule

// File: doc/staged_counter_pair.md
Name: staged_counter_pair

Overview:
- Parametrised two-stage counter pair.
- Primary counter x warms up from 0 to a programmable limit, then holds there.
- Secondary counter y is held at zero during warm-up and only counts once x is at its limit.
- A mode input selects one-shot operation (x holds forever) or cyclic operation (both counters restart when y wraps). Used as a sequencing/timing source for test benches and small controllers.

Parameters:
- WIDTH, 4, bit width of x, y, limit, step.
- STEP_EN, 1, 1 = y increments by the step input; 0 = y increments by 1 and step is ignored.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- en  in  1  count enable; when low, all state and outputs freeze
- clr  in  1  synchronous clear to IDLE
- mode  in  1  0 = one-shot hold, 1 = cyclic restart on y wrap
- limit  in  WIDTH  x target value, latched on leaving IDLE
- step  in  WIDTH  y increment value, sampled every RUN cycle
- x  out  WIDTH  primary counter
- y  out  WIDTH  secondary counter
- state  out  2  00 IDLE, 01 WARM, 10 RUN (11 unused; decodes to IDLE)
- at_limit  out  1  high while state == RUN
- y_wrap  out  1  one-cycle pulse when the y increment carries out of WIDTH bits

Behaviour:
- Reset (async, any time): x=0, y=0, state=IDLE, limit_q=0, y_wrap=0. Takes effect immediately, independent of clk.
- Priority each clock edge: clr > en=0 (freeze) > FSM action.
- clr=1: x=0, y=0, state=IDLE, y_wrap=0. Applies regardless of en.
- en=0: x, y, state and limit_q hold; y_wrap=0.
- IDLE, en=1:
  - limit_q <= limit; x <= 0; y <= 0; state <= WARM.
- WARM, en=1:
  - y stays 0.
  - If x == limit_q: state <= RUN, x unchanged.
  - Else x <= x+1.
  - WARM therefore lasts limit_q+1 enabled cycles; limit_q=0 gives a single WARM cycle.
- RUN, en=1:
  - x holds at limit_q.
  - y <= (y + inc) mod 2^WIDTH, where inc = step when STEP_EN=1, else 1.
  - If the addition carries out: y_wrap=1 for exactly that cycle.
  - mode=0 on wrap: stay in RUN; y keeps the wrapped sum.
  - mode=1 on wrap: x <= 0, y <= 0, state <= WARM (limit_q retained, not resampled).
  - inc=0: y holds and no wrap occurs.
- limit changes after leaving IDLE are ignored until the next pass through IDLE.
- mode is sampled every RUN cycle, so switching mode mid-RUN affects only the next wrap.
- y_wrap is registered and is 0 in every cycle with no carry.
- at_limit is combinational from state; no extra latency.
- Counters never exceed 2^WIDTH-1; all arithmetic is unsigned modulo 2^WIDTH.
- Illegal state 11 is treated as IDLE at the next enabled edge.

Test Plan:
- WIDTH=4, limit=3, mode=0, step=1, en=1 after reset release -> IDLE 1 cycle; x goes 0,1,2,3 with y=0 (4 WARM cycles); then RUN with x=3, y=1,2,…,15,0; y_wrap pulses once at 15->0; state stays RUN.
- Same as above with mode=1 -> on the 15->0 wrap, y_wrap=1, next cycle state=WARM, x=0, y=0, and the sequence repeats identically.
- limit=0, step=5, mode=0 -> one WARM cycle, then y goes 5,10,15,4 with y_wrap on the 15->4 step; x stays 0.
- Drop en for 3 cycles mid-WARM at x=2 -> x, y, state frozen and y_wrap=0; on en returning, x resumes at 3.
- Assert reset asynchronously mid-RUN at y=7 -> x, y, state go 0/IDLE before the next clk edge; clr mid-RUN with en=0 -> cleared at the next edge.
- Change limit from 3 to 9 during WARM -> x still stops at 3; a new IDLE pass after clr picks up 9.
